// File: rtl/console_pkg.sv
// Shared constants, control codes and FSM encoding for the 70x30 text console.
package console_pkg;

    localparam int COLS   = 70;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;
    localparam int CELLS  = COLS * ROWS;

    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    typedef enum logic [1:0] {
        ST_CLR_ALL,
        ST_IDLE,
        ST_PUT,
        ST_CLR_ROW
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/console_addr_map.sv
// Maps a logical (row, col) through the circular row offset to a physical
// character RAM address: prow * 70 + col.
module console_addr_map
    import console_pkg::*;
(
    input  logic [4:0]        row,
    input  logic [6:0]        col,
    input  logic [4:0]        top,
    output logic [ADDR_W-1:0] addr
);

    logic [5:0]        row_sum;
    logic [4:0]        prow;
    logic [ADDR_W-1:0] prow_w;

    always_comb begin
        row_sum = {1'b0, row} + {1'b0, top};
        prow    = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];
        prow_w  = ADDR_W'(prow);
        // 70 = 64 + 4 + 2, kept as shifts so no multiplier is inferred
        addr    = (prow_w << 6) + (prow_w << 2) + (prow_w << 1) + ADDR_W'(col);
    end

endmodule

// File: rtl/text_console_ctrl.sv
// Text console controller: decodes an ASCII byte stream into character RAM
// writes, scrolls via a circular row offset, and shares the RAM port with VGA.
module text_console_ctrl
    import console_pkg::*;
(
    input  logic              pclk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_char,
    output logic              in_ready,
    input  logic              vga_rd,
    input  logic [6:0]        vga_x,
    input  logic [4:0]        vga_y,
    output logic [7:0]        vga_ascii,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [6:0]        cx_q, cx_d;
    logic [4:0]        cy_q, cy_d;
    logic [4:0]        top_q, top_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        put_data_q, put_data_d;
    logic              put_adv_q, put_adv_d;
    logic              rd_q, rd_d;

    logic [ADDR_W-1:0] vga_addr;
    logic [ADDR_W-1:0] wr_map_addr;
    logic [4:0]        wr_row;
    logic [6:0]        wr_col;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    logic              adv_scroll;
    logic [4:0]        adv_cy;
    logic [4:0]        adv_top;

    // Row clears always target logical row 29 under the already-advanced top
    assign wr_row = (state_q == ST_CLR_ROW) ? LAST_ROW : cy_q;
    assign wr_col = (state_q == ST_CLR_ROW) ? cnt_q[6:0] : cx_q;

    console_addr_map u_vga_map (
        .row  (vga_y),
        .col  (vga_x),
        .top  (top_q),
        .addr (vga_addr)
    );

    console_addr_map u_wr_map (
        .row  (wr_row),
        .col  (wr_col),
        .top  (top_q),
        .addr (wr_map_addr)
    );

    assign adv_scroll = (cy_q == LAST_ROW);
    assign adv_cy     = adv_scroll ? cy_q : cy_q + 5'd1;
    assign adv_top    = (top_q == LAST_ROW) ? 5'd0 : top_q + 5'd1;

    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        top_d      = top_q;
        cnt_d      = cnt_q;
        put_data_d = put_data_q;
        put_adv_d  = put_adv_q;
        rd_d       = vga_rd;
        wr_en      = 1'b0;
        wr_addr    = wr_map_addr;
        wr_data    = BLANK;
        in_ready   = 1'b0;
        busy       = 1'b0;

        case (state_q)
            ST_CLR_ALL: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                if (!vga_rd) begin
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end

            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_printable(in_char)) begin
                        put_data_d = in_char;
                        put_adv_d  = 1'b1;
                        state_d    = ST_PUT;
                    end else begin
                        case (in_char)
                            CH_LF: begin
                                cx_d = '0;
                                cy_d = adv_cy;
                                if (adv_scroll) begin
                                    top_d   = adv_top;
                                    cnt_d   = '0;
                                    state_d = ST_CLR_ROW;
                                end
                            end
                            CH_CR: cx_d = '0;
                            CH_BS: begin
                                // No reverse wrap: backspace at column 0 is dropped
                                if (cx_q != 7'd0) begin
                                    cx_d       = cx_q - 7'd1;
                                    put_data_d = BLANK;
                                    put_adv_d  = 1'b0;
                                    state_d    = ST_PUT;
                                end
                            end
                            CH_FF: begin
                                cx_d    = '0;
                                cy_d    = '0;
                                top_d   = '0;
                                cnt_d   = '0;
                                state_d = ST_CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            ST_PUT: begin
                wr_en   = 1'b1;
                wr_data = put_data_q;
                if (!vga_rd) begin
                    state_d = ST_IDLE;
                    if (put_adv_q) begin
                        if (cx_q == LAST_COL) begin
                            cx_d = '0;
                            cy_d = adv_cy;
                            if (adv_scroll) begin
                                top_d   = adv_top;
                                cnt_d   = '0;
                                state_d = ST_CLR_ROW;
                            end
                        end else begin
                            cx_d = cx_q + 7'd1;
                        end
                    end
                end
            end

            ST_CLR_ROW: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (!vga_rd) begin
                    if (cnt_q[6:0] == LAST_COL) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_CLR_ALL;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q    <= ST_CLR_ALL;
            cx_q       <= '0;
            cy_q       <= '0;
            top_q      <= '0;
            cnt_q      <= '0;
            put_data_q <= BLANK;
            put_adv_q  <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            top_q      <= top_d;
            cnt_q      <= cnt_d;
            put_data_q <= put_data_d;
            put_adv_q  <= put_adv_d;
            rd_q       <= rd_d;
        end
    end

    // VGA always wins the port; a pending write simply waits
    assign mem_addr  = vga_rd ? vga_addr : wr_addr;
    assign mem_we    = wr_en && !vga_rd && !reset;
    assign mem_wdata = wr_data;
    assign vga_ascii = rd_q ? mem_rdata : BLANK;
    assign cursor_x  = cx_q;
    assign cursor_y  = cy_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Randomised bench for text_console_ctrl: a queue-of-writes console model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_text_console_ctrl;

    localparam int NCOLS  = 70;
    localparam int NROWS  = 30;
    localparam int NCELLS = 2100;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = 8'h00;
    logic        in_ready;
    logic        vga_rd = 1'b0;
    logic [6:0]  vga_x = 7'd0;
    logic [4:0]  vga_y = 5'd0;
    logic [7:0]  vga_ascii;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    text_console_ctrl dut (
        .pclk      (pclk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_char   (in_char),
        .in_ready  (in_ready),
        .vga_rd    (vga_rd),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_ascii (vga_ascii),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .busy      (busy)
    );

    // Synchronous single-port character RAM
    logic [7:0] ram [0:4095];
    always @(posedge pclk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        bit          bsy;
        int          top_after;
    } wr_t;

    wr_t        q[$];
    int         cx_m = 0, cy_m = 0, top_m = 0;
    bit         started = 0;
    logic [7:0] mm [0:NCELLS-1];
    bit         known [0:NCELLS-1];
    bit         exp_known = 0;
    logic [7:0] exp_ascii = 8'h20;

    function automatic int map(input int row, input int col, input int top);
        return ((row + top) % NROWS) * NCOLS + col;
    endfunction

    task automatic push_wr(input int a, input logic [7:0] d, input bit b, input int t);
        wr_t e;
        e.addr = 12'(a);
        e.data = d;
        e.bsy = b;
        e.top_after = t;
        q.push_back(e);
    endtask

    task automatic push_row_clear(input int t);
        for (int c = 0; c < NCOLS; c++) push_wr(map(NROWS - 1, c, t), 8'h20, 1'b1, t);
    endtask

    task automatic push_full_clear();
        for (int i = 0; i < NCELLS; i++) push_wr(i, 8'h20, 1'b1, 0);
    endtask

    task automatic decode(input logic [7:0] c);
        int  a0;
        int  ntop;
        bit  scroll;
        if (c >= 8'h20 && c <= 8'h7E) begin
            a0 = map(cy_m, cx_m, top_m);
            scroll = (cx_m == NCOLS - 1) && (cy_m == NROWS - 1);
            ntop = scroll ? (top_m + 1) % NROWS : top_m;
            push_wr(a0, c, 1'b0, ntop);
            if (scroll) push_row_clear(ntop);
            if (cx_m == NCOLS - 1) begin
                cx_m = 0;
                if (cy_m < NROWS - 1) cy_m++;
            end else begin
                cx_m++;
            end
        end else if (c == 8'h0A) begin
            cx_m = 0;
            if (cy_m < NROWS - 1) cy_m++;
            else begin
                top_m = (top_m + 1) % NROWS;
                push_row_clear(top_m);
            end
        end else if (c == 8'h0D) begin
            cx_m = 0;
        end else if (c == 8'h08) begin
            if (cx_m > 0) begin
                cx_m--;
                push_wr(map(cy_m, cx_m, top_m), 8'h20, 1'b0, top_m);
            end
        end else if (c == 8'h0C) begin
            cx_m = 0;
            cy_m = 0;
            top_m = 0;
            push_full_clear();
        end
    endtask

    always @(negedge pclk) begin : compare
        wr_t e;
        int  a;
        if (reset) begin
            if (started) chk("mem_we_in_reset", mem_we, 0);
            started = 1;
            q.delete();
            push_full_clear();
            cx_m = 0;
            cy_m = 0;
            top_m = 0;
            exp_known = 1;
            exp_ascii = 8'h20;
        end else if (started) begin
            chk("in_ready", in_ready, q.size() == 0);
            chk("busy", busy, (q.size() != 0) && q[0].bsy);
            if (vga_rd) begin
                chk("rd_we", mem_we, 0);
                chk("rd_addr", mem_addr, map(vga_y, vga_x, top_m));
            end else if (q.size() != 0) begin
                chk("wr_we", mem_we, 1);
                chk("wr_addr", mem_addr, q[0].addr);
                chk("wr_data", mem_wdata, q[0].data);
            end else begin
                chk("idle_we", mem_we, 0);
            end
            if (q.size() == 0) begin
                chk("cursor_x", cursor_x, cx_m);
                chk("cursor_y", cursor_y, cy_m);
            end
            if (exp_known) chk("vga_ascii", vga_ascii, exp_ascii);

            // advance the model across the coming edge
            if (vga_rd) begin
                a = map(vga_y, vga_x, top_m);
                exp_known = known[a];
                exp_ascii = mm[a];
            end else begin
                exp_known = 1;
                exp_ascii = 8'h20;
            end
            if (q.size() != 0) begin
                if (!vga_rd) begin
                    e = q.pop_front();
                    mm[e.addr] = e.data;
                    known[e.addr] = 1;
                    top_m = e.top_after;
                end
            end else if (in_valid) begin
                decode(in_char);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Presents a byte until accepted, then samples the port in the following cycle
    task automatic send(input logic [7:0] c, output logic we, output logic [11:0] a,
                        output logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_char = c;
        @(negedge pclk);
        while (!in_ready && n < 5000) begin
            @(negedge pclk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge pclk);
        #1 in_valid = 1'b0;
        @(negedge pclk);
        we = mem_we;
        a = mem_addr;
        d = mem_wdata;
        tick();
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        @(negedge pclk);
        while (!in_ready && n < bound) begin
            @(negedge pclk);
            n++;
        end
        if (!in_ready) chk("idle_timeout", 0, 1);
        tick();
    endtask

    function automatic logic [7:0] pick_char();
        int r;
        r = $urandom_range(0, 999);
        if (r < 600) return 8'($urandom_range(32, 126));
        if (r < 750) return 8'h0A;
        if (r < 800) return 8'h0D;
        if (r < 920) return 8'h08;
        if (r < 922) return 8'h0C;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin : stim
        logic        we;
        logic [11:0] a;
        logic [7:0]  d;
        int          nok;
        int          nbad;
        int          burst;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // power-up clear: 2100 sequential blank writes
        nok = 0;
        for (int i = 0; i < NCELLS; i++) begin
            @(negedge pclk);
            if (mem_we && mem_addr == 12'(i) && mem_wdata == 8'h20 && busy) nok++;
        end
        @(negedge pclk);
        chk("init_writes", nok, 2100);
        chk("init_ready", in_ready, 1);
        chk("init_busy", busy, 0);
        tick();

        send(8'h41, we, a, d);
        chk("A_we", we, 1);
        chk("A_addr", a, 0);
        chk("A_data", d, 8'h41);
        @(negedge pclk);
        chk("A_cx", cursor_x, 1);
        tick();

        // walk down to row 29, then scroll once
        send(8'h0D, we, a, d);
        for (int i = 0; i < 29; i++) send(8'h0A, we, a, d);
        send(8'h0A, we, a, d);
        chk("scroll_we", we, 1);
        chk("scroll_addr", a, 0);
        chk("scroll_data", d, 8'h20);
        wait_idle(200);
        vga_rd = 1'b1;
        vga_y = 5'd29;
        vga_x = 7'd0;
        @(negedge pclk);
        chk("vga29_addr", mem_addr, 0);
        chk("scroll_cx", cursor_x, 0);
        chk("scroll_cy", cursor_y, 29);
        tick();
        vga_y = 5'd0;
        vga_x = 7'd3;
        @(negedge pclk);
        chk("vga0_addr", mem_addr, 73);
        tick();

        // stalled PUT: vga_rd held 20 cycles starting at the accept cycle
        vga_y = 5'd29;
        vga_x = 7'd0;
        send(8'h41, we, a, d);
        chk("stall_we0", we, 0);
        nbad = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge pclk);
            if (mem_we) nbad++;
            tick();
        end
        chk("stall_we_hold", nbad, 0);
        vga_rd = 1'b0;
        @(negedge pclk);
        chk("stall_we1", mem_we, 1);
        chk("stall_addr", mem_addr, 0);
        chk("stall_data", mem_wdata, 8'h41);
        tick();
        @(negedge pclk);
        chk("stall_cx", cursor_x, 1);
        tick();

        // backspace at column 5 and at column 0
        send(8'h0D, we, a, d);
        for (int i = 0; i < 5; i++) send(8'h78, we, a, d);
        send(8'h42, we, a, d);
        chk("B_addr", a, 5);
        chk("B_data", d, 8'h42);
        send(8'h08, we, a, d);
        chk("bs_we", we, 1);
        chk("bs_addr", a, 5);
        chk("bs_data", d, 8'h20);
        @(negedge pclk);
        chk("bs_cx", cursor_x, 5);
        tick();
        send(8'h0D, we, a, d);
        send(8'h08, we, a, d);
        chk("bs0_we", we, 0);
        @(negedge pclk);
        chk("bs0_cx", cursor_x, 0);
        tick();

        // reset in the middle of a row clear
        send(8'h0A, we, a, d);
        chk("scroll2_addr", a, 70);
        repeat (30) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge pclk);
        chk("rst_busy", busy, 1);
        chk("rst_ready", in_ready, 0);
        chk("rst_cx", cursor_x, 0);
        chk("rst_cy", cursor_y, 0);
        chk("rst_we", mem_we, 1);
        chk("rst_addr", mem_addr, 0);
        tick();
        wait_idle(2300);

        // randomised traffic
        burst = 0;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            reset = ($urandom_range(0, 5999) == 0);
            if (burst > 0) begin
                burst--;
                vga_rd = 1'b1;
            end else if ($urandom_range(0, 99) < 3) begin
                burst = $urandom_range(5, 25);
                vga_rd = 1'b1;
            end else begin
                vga_rd = ($urandom_range(0, 3) == 0);
            end
            vga_x = 7'($urandom_range(0, 69));
            vga_y = 5'($urandom_range(0, 29));
            in_valid = 1'($urandom_range(0, 1));
            in_char = pick_char();
            tick();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        vga_rd = 1'b0;
        wait_idle(3000);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
